// File: rtl/risc16_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle between the boot loader and its surroundings.
// slave = loader side, master = byte source / imem / core side.
interface risc16_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] m_addr;
  logic [15:0] m_din;
  logic        m_we;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, m_addr, m_din, m_we, cpu_rst, busy, done, err
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, m_addr, m_din, m_we, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/risc16_boot_loader.sv
// Framed byte-stream loader: SYNC, LEN_H, LEN_L, {hi,lo} words, CHK -> imem writes.
// Holds the core in reset until a frame with a matching mod-256 checksum has been loaded.
module risc16_boot_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned MAX_WORDS   = 32768,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  risc16_boot_loader_if.slave  bus
);
  localparam int unsigned   TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK, S_RUN, S_ERR
  } state_e;

  state_e        state_q;
  logic [7:0]    len_h_q;
  logic [7:0]    hi_q;
  logic [7:0]    sum_q;
  logic [15:0]   words_q;
  logic [15:0]   waddr_q;
  logic [15:0]   m_addr_q;
  logic [15:0]   m_din_q;
  logic [TW-1:0] idle_q;
  logic          m_we_q;
  logic          cpu_rst_q;
  logic          done_q;
  logic          err_q;
  logic          rx_ready_q;

  logic          acc;
  logic          busy;
  logic [15:0]   len_d;
  logic [7:0]    sum_d;

  assign acc   = bus.rx_valid & rx_ready_q;
  assign busy  = (state_q == S_LEN_H) || (state_q == S_LEN_L) || (state_q == S_DATA_H) ||
                 (state_q == S_DATA_L) || (state_q == S_CHK);
  assign len_d = {len_h_q, bus.rx_data};
  assign sum_d = sum_q + bus.rx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_h_q    <= '0;
      hi_q       <= '0;
      sum_q      <= '0;
      words_q    <= '0;
      waddr_q    <= BASE_ADDR;
      m_addr_q   <= BASE_ADDR;
      m_din_q    <= '0;
      idle_q     <= '0;
      m_we_q     <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b1;
    end else begin
      m_we_q <= 1'b0;

      // Inter-byte idle timer only runs while a frame is open; any accepted byte reloads it.
      if (busy && !acc && (TIMEOUT_CYC != 0) && (idle_q == TMO_LAST)) begin
        state_q <= S_ERR;
        err_q   <= 1'b1;
        idle_q  <= '0;
      end else if (busy) begin
        idle_q <= acc ? '0 : idle_q + TW'(1);
      end else begin
        idle_q <= '0;
      end

      if (acc) begin
        case (state_q)
          S_IDLE, S_ERR: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state_q <= S_LEN_H;
              sum_q   <= '0;
              err_q   <= 1'b0;
              waddr_q <= BASE_ADDR;
            end
          end
          S_LEN_H: begin
            len_h_q <= bus.rx_data;
            sum_q   <= sum_d;
            state_q <= S_LEN_L;
          end
          S_LEN_L: begin
            sum_q   <= sum_d;
            words_q <= len_d;
            if (32'(len_d) > MAX_WORDS) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA_H;
            end
          end
          S_DATA_H: begin
            hi_q    <= bus.rx_data;
            sum_q   <= sum_d;
            state_q <= S_DATA_L;
          end
          S_DATA_L: begin
            sum_q    <= sum_d;
            m_we_q   <= 1'b1;
            m_din_q  <= {hi_q, bus.rx_data};
            m_addr_q <= waddr_q;
            waddr_q  <= waddr_q + 16'd2;
            words_q  <= words_q - 16'd1;
            state_q  <= (words_q == 16'd1) ? S_CHK : S_DATA_H;
          end
          S_CHK: begin
            if (bus.rx_data == sum_q) begin
              state_q    <= S_RUN;
              cpu_rst_q  <= 1'b0;
              done_q     <= 1'b1;
              rx_ready_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_din    = m_din_q;
  assign bus.m_we     = m_we_q;
  assign bus.cpu_rst  = cpu_rst_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_risc16_boot_loader.sv
// Directed and randomized frame bench for risc16_boot_loader; expected imem writes and
// status flags are derived per frame from length, payload and checksum arithmetic.
module tb_risc16_boot_loader;
  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 4;
  localparam int          TMO  = 16;

  logic clk;
  logic rst;
  risc16_boot_loader_if bus ();

  risc16_boot_loader #(
    .BASE_ADDR  (BASE),
    .MAX_WORDS  (MAXW),
    .TIMEOUT_CYC(TMO),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] got_w[$];
  logic [31:0] exp_w[$];
  logic [7:0]  tx_bytes[$];
  logic [15:0] tx_words[$];

  // Every cycle with m_we high is one imem write.
  always @(negedge clk) begin
    if (bus.m_we === 1'b1) got_w.push_back({bus.m_addr, bus.m_din});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_w.delete();
    exp_w.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_cpu_rst"},  32'(bus.cpu_rst),  32'd1);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check({tag, "_m_we"},     32'(bus.m_we),     32'd0);
    check({tag, "_m_addr"},   32'(bus.m_addr),   32'(BASE));
    check({tag, "_m_din"},    32'(bus.m_din),    32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_err"},      32'(bus.err),      32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic send_all(input int gap_max);
    foreach (tx_bytes[i]) begin
      send_byte(tx_bytes[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
    end
    tx_bytes.delete();
  endtask

  function automatic logic [7:0] garbage();
    logic [7:0] b = 8'($urandom_range(0, 255));
    return (b == 8'hA5) ? 8'h5A : b;
  endfunction

  // chk_mode: 0 = correct checksum, 1 = wrong checksum, 2 = no checksum byte.
  task automatic build_frame(input logic [15:0] len, input int chk_mode);
    logic [7:0] s;
    s = len[15:8] + len[7:0];
    tx_bytes.push_back(8'hA5);
    tx_bytes.push_back(len[15:8]);
    tx_bytes.push_back(len[7:0]);
    foreach (tx_words[i]) begin
      tx_bytes.push_back(tx_words[i][15:8]);
      tx_bytes.push_back(tx_words[i][7:0]);
      s = s + tx_words[i][15:8] + tx_words[i][7:0];
    end
    if (chk_mode == 0) tx_bytes.push_back(s);
    if (chk_mode == 1) tx_bytes.push_back(s + 8'($urandom_range(1, 255)));
  endtask

  task automatic expect_words();
    foreach (tx_words[i]) exp_w.push_back({16'(BASE + 16'(2 * i)), tx_words[i]});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(got_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("%s_write%0d", tag, i), got_w[i], exp_w[i]);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    do_reset();
    check_reset_vals("reset");

    // Test 1: two-word frame, cpu_rst drops the cycle after the checksum byte.
    tx_bytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_all(0);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hC0;
    check("t1_cpu_rst_before_chk", 32'(bus.cpu_rst), 32'd1);
    check("t1_busy_in_chk", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
    check("t1_cpu_rst_after_chk", 32'(bus.cpu_rst), 32'd0);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("t1_busy", 32'(bus.busy), 32'd0);
    exp_w = '{32'h0000_1234, 32'h0002_ABCD};
    check_writes("t1");

    // Test 2: bad checksum still writes, then a good retransmission loads.
    do_reset();
    tx_bytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    send_all(0);
    @(negedge clk);
    check("t2_err", 32'(bus.err), 32'd1);
    check("t2_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("t2_done", 32'(bus.done), 32'd0);
    tx_bytes = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    send_all(0);
    @(negedge clk);
    check("t2_err_cleared", 32'(bus.err), 32'd0);
    check("t2_done", 32'(bus.done), 32'd1);
    check("t2_cpu_rst_released", 32'(bus.cpu_rst), 32'd0);
    exp_w = '{32'h0000_1234, 32'h0002_ABCD, 32'h0000_1234, 32'h0002_ABCD};
    check_writes("t2");

    // Test 3: garbage ahead of an empty frame.
    do_reset();
    tx_bytes = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_all(0);
    @(negedge clk);
    check("t3_done", 32'(bus.done), 32'd1);
    check("t3_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check_writes("t3");

    // Test 4: inter-byte timeout inside a frame.
    do_reset();
    tx_bytes = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_all(0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("t4_err_before_timeout", 32'(bus.err), 32'd0);
    check("t4_busy_before_timeout", 32'(bus.busy), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t4_err_after_timeout", 32'(bus.err), 32'd1);
    check("t4_busy_after_timeout", 32'(bus.busy), 32'd0);
    check("t4_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check_writes("t4");

    // Test 5: oversize length, discarded payload, back-to-back resync.
    do_reset();
    tx_bytes = '{8'hA5, 8'h00, 8'h05};
    send_all(0);
    @(negedge clk);
    check("t5_err_after_len", 32'(bus.err), 32'd1);
    check("t5_busy_after_len", 32'(bus.busy), 32'd0);
    tx_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_all(0);
    send_byte(8'hA5);
    @(negedge clk);
    check("t5_err_cleared_by_sync", 32'(bus.err), 32'd1 - 32'd1);
    check("t5_busy_after_sync", 32'(bus.busy), 32'd1);
    tx_bytes = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h79};
    send_all(0);
    @(negedge clk);
    check("t5_done", 32'(bus.done), 32'd1);
    exp_w = '{32'h0000_ABCD};
    check_writes("t5");

    // Test 6: reset after the first word of a three-word frame.
    do_reset();
    tx_bytes = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_all(0);
    @(negedge clk);
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h33;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rx_valid = 1'b0;
    check_reset_vals("t6_after_rst");
    repeat (3) @(posedge clk);
    exp_w = '{32'h0000_1122};
    check_writes("t6_abort");
    got_w.delete();
    exp_w.delete();
    tx_words = '{16'h1122, 16'h3344, 16'h5566};
    build_frame(16'd3, 0);
    expect_words();
    send_all(0);
    @(negedge clk);
    check("t6_done", 32'(bus.done), 32'd1);
    check_writes("t6_reload");

    // Randomized rounds: some failing frames, then one good frame.
    for (int r = 0; r < 20; r++) begin
      int nbad;
      do_reset();
      nbad = $urandom_range(0, 3);
      for (int f = 0; f < nbad; f++) begin
        int kind;
        logic [15:0] len;
        repeat ($urandom_range(0, 2)) tx_bytes.push_back(garbage());
        kind = $urandom_range(0, 1);
        tx_words.delete();
        if (kind == 0) begin
          len = 16'($urandom_range(0, MAXW));
          for (int i = 0; i < int'(len); i++) tx_words.push_back(16'($urandom));
          build_frame(len, 1);
          expect_words();
        end else begin
          len = 16'($urandom_range(MAXW + 1, 65535));
          build_frame(len, 2);
          repeat ($urandom_range(0, 3)) tx_bytes.push_back(garbage());
        end
        send_all(5);
        @(negedge clk);
        check($sformatf("rnd%0d_f%0d_err", r, f), 32'(bus.err), 32'd1);
        check($sformatf("rnd%0d_f%0d_cpu_rst", r, f), 32'(bus.cpu_rst), 32'd1);
      end
      repeat ($urandom_range(0, 2)) tx_bytes.push_back(garbage());
      tx_words.delete();
      for (int i = 0; i < int'($urandom_range(0, MAXW)); i++) tx_words.push_back(16'($urandom));
      build_frame(16'(tx_words.size()), 0);
      expect_words();
      send_all(5);
      @(negedge clk);
      check($sformatf("rnd%0d_done", r), 32'(bus.done), 32'd1);
      check($sformatf("rnd%0d_err", r), 32'(bus.err), 32'd0);
      check($sformatf("rnd%0d_cpu_rst", r), 32'(bus.cpu_rst), 32'd0);
      check_writes($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
